// File: rtl/wfg_drive_spi_if.sv
// rtl/wfg_drive_spi_if.sv - sample stream handshake between a stimulus block and wfg_drive_spi
// Signals:
//   wfg_drive_spi_tvalid_i  producer has a sample
//   wfg_drive_spi_tready_o  consumer accepts a sample this cycle
//   wfg_drive_spi_tdata_i   signed 18-bit sample
interface wfg_drive_spi_if;
    logic        wfg_drive_spi_tvalid_i;
    logic        wfg_drive_spi_tready_o;
    logic [17:0] wfg_drive_spi_tdata_i;

    modport master (
        output wfg_drive_spi_tvalid_i,
        output wfg_drive_spi_tdata_i,
        input  wfg_drive_spi_tready_o
    );

    modport slave (
        input  wfg_drive_spi_tvalid_i,
        input  wfg_drive_spi_tdata_i,
        output wfg_drive_spi_tready_o
    );
endinterface

// File: rtl/wfg_drive_spi.sv
// rtl/wfg_drive_spi.sv - single-lane SPI transmitter (CPHA=0) fed by an 18-bit sample stream
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   s_axis (slave)           sample stream; tready high only in IDLE while enabled
//   ctrl_en_q_i              allow new words to be accepted
//   clkcfg_div_q_i           SCLK half-period minus 1 (D = div+1 clk cycles)
//   ctrl_cpol_q_i            SCLK idle level
//   ctrl_lsbfirst_q_i        bit order, 1 = LSB first
//   ctrl_sspol_q_i           CS active level
//   ctrl_dff_q_i             frame width: 00 = 8, 01 = 16, 1x = 18 (MSB-aligned field of tdata)
//   wfg_drive_spi_sclk_o     SPI clock
//   wfg_drive_spi_cs_o       chip select
//   wfg_drive_spi_sdo_o      serial data out
module wfg_drive_spi (
    input  logic                 clk,
    input  logic                 rst,
    wfg_drive_spi_if.slave       s_axis,
    input  logic                 ctrl_en_q_i,
    input  logic [7:0]           clkcfg_div_q_i,
    input  logic                 ctrl_cpol_q_i,
    input  logic                 ctrl_lsbfirst_q_i,
    input  logic                 ctrl_sspol_q_i,
    input  logic [1:0]           ctrl_dff_q_i,
    output logic                 wfg_drive_spi_sclk_o,
    output logic                 wfg_drive_spi_cs_o,
    output logic                 wfg_drive_spi_sdo_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_div;
    logic [5:0]  r_edge;
    logic [5:0]  r_n2;
    logic [17:0] r_shift;
    logic        r_lsb;
    logic        r_sspol;
    logic        r_sclk;
    logic        r_cs;
    logic        r_sdo;

    logic        w_ready;
    logic        w_hs;
    logic        w_tick;
    logic [17:0] w_right;
    logic [17:0] w_left;
    logic [17:0] w_load;
    logic [5:0]  w_n2;
    logic        w_first;
    logic [5:0]  w_edge_nxt;
    logic [17:0] w_shifted;
    logic        w_next_bit;

    assign w_ready = (r_state == ST_IDLE) & ctrl_en_q_i & ~rst;
    assign w_hs    = s_axis.wfg_drive_spi_tvalid_i & w_ready;
    assign w_tick  = (r_cnt == r_div);

    assign s_axis.wfg_drive_spi_tready_o = w_ready;

    // The selected field is kept in two alignments: right-aligned for
    // LSB-first (bit 0 leaves first) and left-aligned for MSB-first
    // (bit 17 leaves first), so shifting never needs a variable index.
    always_comb begin
        w_right = s_axis.wfg_drive_spi_tdata_i;
        w_left  = s_axis.wfg_drive_spi_tdata_i;
        w_n2    = 6'd36;
        case (ctrl_dff_q_i)
            2'b00: begin
                w_right = {10'b0, s_axis.wfg_drive_spi_tdata_i[17:10]};
                w_left  = {s_axis.wfg_drive_spi_tdata_i[17:10], 10'b0};
                w_n2    = 6'd16;
            end
            2'b01: begin
                w_right = {2'b0, s_axis.wfg_drive_spi_tdata_i[17:2]};
                w_left  = {s_axis.wfg_drive_spi_tdata_i[17:2], 2'b0};
                w_n2    = 6'd32;
            end
            default: begin
                w_right = s_axis.wfg_drive_spi_tdata_i;
                w_left  = s_axis.wfg_drive_spi_tdata_i;
                w_n2    = 6'd36;
            end
        endcase
    end

    assign w_load     = ctrl_lsbfirst_q_i ? w_right : w_left;
    assign w_first    = ctrl_lsbfirst_q_i ? w_right[0] : w_left[17];
    assign w_edge_nxt = r_edge + 6'd1;
    assign w_shifted  = r_lsb ? {1'b0, r_shift[17:1]} : {r_shift[16:0], 1'b0};
    assign w_next_bit = r_lsb ? r_shift[1] : r_shift[16];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_div   <= 8'd0;
            r_edge  <= 6'd0;
            r_n2    <= 6'd0;
            r_shift <= 18'd0;
            r_lsb   <= 1'b0;
            r_sspol <= 1'b0;
            r_sclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_sdo   <= 1'b0;
        end else begin
            // Half-period timer; free-runs 0..div in every busy state.
            if (r_state != ST_IDLE) begin
                r_cnt <= w_tick ? 8'd0 : r_cnt + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    // Idle bus levels track the live configuration.
                    r_sclk <= ctrl_cpol_q_i;
                    r_cs   <= ~ctrl_sspol_q_i;
                    r_cnt  <= 8'd0;
                    if (w_hs) begin
                        r_shift <= w_load;
                        r_n2    <= w_n2;
                        r_lsb   <= ctrl_lsbfirst_q_i;
                        r_sspol <= ctrl_sspol_q_i;
                        r_div   <= clkcfg_div_q_i;
                        r_edge  <= 6'd0;
                        r_sdo   <= w_first;
                        r_cs    <= ctrl_sspol_q_i;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_sclk  <= ~r_sclk;
                        r_edge  <= 6'd1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        r_edge <= w_edge_nxt;
                        if (w_edge_nxt == r_n2) begin
                            r_state <= ST_HOLD;
                        end else if (!w_edge_nxt[0]) begin
                            // Trailing edge: present the next bit so it is
                            // stable at the following leading edge.
                            r_sdo   <= w_next_bit;
                            r_shift <= w_shifted;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_cs    <= ~r_sspol;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wfg_drive_spi_sclk_o = r_sclk;
    assign wfg_drive_spi_cs_o   = r_cs;
    assign wfg_drive_spi_sdo_o  = r_sdo;

endmodule

// File: tb/tb_wfg_drive_spi.sv
// tb/tb_wfg_drive_spi.sv - directed self-checking bench for wfg_drive_spi
module tb_wfg_drive_spi;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic       cpol;
    logic       lsbf;
    logic       sspol;
    logic [1:0] dff;
    logic       sclk;
    logic       cs;
    logic       sdo;

    int checks   = 0;
    int failures = 0;

    wfg_drive_spi_if s_if ();

    wfg_drive_spi dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_axis               (s_if.slave),
        .ctrl_en_q_i          (en),
        .clkcfg_div_q_i       (div),
        .ctrl_cpol_q_i        (cpol),
        .ctrl_lsbfirst_q_i    (lsbf),
        .ctrl_sspol_q_i       (sspol),
        .ctrl_dff_q_i         (dff),
        .wfg_drive_spi_sclk_o (sclk),
        .wfg_drive_spi_cs_o   (cs),
        .wfg_drive_spi_sdo_o  (sdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the sample point just after the handshake edge (c = 0).
    // Records bits on leading SCLK edges, counts CS-active cycles and
    // returns the cycle at which tready is first seen high again.
    task automatic run_word(input logic cpol_w, input logic sspol_w, input logic lsb_w,
                            input bit toggle, input logic [17:0] next_data,
                            input int en_drop_c, input int max_c,
                            output logic [17:0] word, output int nbits, output int first_lead,
                            output int cs_cycles, output int ready_c);
        logic prev;
        prev       = cpol_w;
        word       = '0;
        nbits      = 0;
        first_lead = -1;
        cs_cycles  = 0;
        ready_c    = -1;
        for (int c = 0; c <= max_c; c++) begin
            if (c > 0) step();
            if (c == en_drop_c) en = 1'b0;
            if (sclk !== prev && sclk === ~cpol_w) begin
                if (first_lead < 0) first_lead = c;
                if (lsb_w) begin
                    if (nbits < 18) word[nbits] = sdo;
                end else begin
                    word = {word[16:0], sdo};
                end
                nbits++;
            end
            prev = sclk;
            if (cs === sspol_w) cs_cycles++;
            if (s_if.wfg_drive_spi_tready_o === 1'b1) begin
                ready_c = c;
                if (toggle) s_if.wfg_drive_spi_tdata_i = next_data;
                break;
            end
            if (toggle) s_if.wfg_drive_spi_tdata_i = 18'($urandom);
        end
    endtask

    task automatic start_word(input logic [17:0] data);
        s_if.wfg_drive_spi_tvalid_i = 1'b1;
        s_if.wfg_drive_spi_tdata_i  = data;
        step();
        s_if.wfg_drive_spi_tvalid_i = 1'b0;
    endtask

    logic [17:0] word;
    int          nbits;
    int          first_lead;
    int          cs_cycles;
    int          ready_c;

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        div   = 8'd0;
        cpol  = 1'b0;
        lsbf  = 1'b0;
        sspol = 1'b0;
        dff   = 2'b00;
        s_if.wfg_drive_spi_tvalid_i = 1'b0;
        s_if.wfg_drive_spi_tdata_i  = '0;

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sclk",   32'(sclk), 32'd0);
            chk("rst_cs",     32'(cs), 32'd1);
            chk("rst_sdo",    32'(sdo), 32'd0);
            chk("rst_tready", 32'(s_if.wfg_drive_spi_tready_o), 32'd0);
        end
        rst = 1'b0;
        step();
        chk("post_rst_tready", 32'(s_if.wfg_drive_spi_tready_o), 32'd1);

        // Mode 0, 8-bit, MSB-first, div=0
        start_word(18'h2A5FF);
        run_word(1'b0, 1'b0, 1'b0, 1'b0, '0, -1, 400, word, nbits, first_lead, cs_cycles, ready_c);
        chk("m0_word",  32'(word), 32'h0A9);
        chk("m0_nbits", 32'(nbits), 32'd8);
        chk("m0_lead",  32'(first_lead), 32'd1);
        chk("m0_cs",    32'(cs_cycles), 32'd17);
        chk("m0_ready", 32'(ready_c), 32'd18);

        // 18-bit, LSB-first, div=3
        dff  = 2'b10;
        lsbf = 1'b1;
        div  = 8'd3;
        start_word(18'h00001);
        run_word(1'b0, 1'b0, 1'b1, 1'b0, '0, -1, 400, word, nbits, first_lead, cs_cycles, ready_c);
        chk("lsb_word",  32'(word), 32'h00001);
        chk("lsb_nbits", 32'(nbits), 32'd18);
        chk("lsb_lead",  32'(first_lead), 32'd4);
        chk("lsb_cs",    32'(cs_cycles), 32'd148);
        chk("lsb_ready", 32'(ready_c), 32'd152);

        // Back-pressure: tvalid held, tdata toggled while tready=0
        dff  = 2'b00;
        lsbf = 1'b0;
        div  = 8'd0;
        s_if.wfg_drive_spi_tvalid_i = 1'b1;
        s_if.wfg_drive_spi_tdata_i  = 18'h3FFFF;
        step();
        run_word(1'b0, 1'b0, 1'b0, 1'b1, 18'h00000, -1, 400, word, nbits, first_lead, cs_cycles, ready_c);
        chk("bp_a_word",  32'(word), 32'h0FF);
        chk("bp_a_ready", 32'(ready_c), 32'd18);
        chk("bp_pre_cs",  32'(cs), 32'd1);
        step();
        chk("bp_b_accept_cs", 32'(cs), 32'd0);
        s_if.wfg_drive_spi_tvalid_i = 1'b0;
        run_word(1'b0, 1'b0, 1'b0, 1'b0, '0, -1, 400, word, nbits, first_lead, cs_cycles, ready_c);
        chk("bp_b_word",  32'(word), 32'h000);
        chk("bp_b_nbits", 32'(nbits), 32'd8);
        chk("bp_b_ready", 32'(ready_c), 32'd18);

        // Mode 2, active-high CS, 16-bit, div=1
        cpol  = 1'b1;
        sspol = 1'b1;
        dff   = 2'b01;
        div   = 8'd1;
        step();
        chk("m2_idle_sclk", 32'(sclk), 32'd1);
        chk("m2_idle_cs",   32'(cs), 32'd0);
        start_word(18'h15555);
        chk("m2_cs_active", 32'(cs), 32'd1);
        run_word(1'b1, 1'b1, 1'b0, 1'b0, '0, -1, 400, word, nbits, first_lead, cs_cycles, ready_c);
        chk("m2_word",  32'(word), 32'h5555);
        chk("m2_nbits", 32'(nbits), 32'd16);
        chk("m2_lead",  32'(first_lead), 32'd2);
        chk("m2_cs",    32'(cs_cycles), 32'd66);
        chk("m2_ready", 32'(ready_c), 32'd68);

        // Disable mid-word at SCLK edge 3 (div=1 -> cycle 6)
        cpol  = 1'b0;
        sspol = 1'b0;
        dff   = 2'b00;
        step();
        start_word(18'h0CC00);
        run_word(1'b0, 1'b0, 1'b0, 1'b0, '0, 6, 60, word, nbits, first_lead, cs_cycles, ready_c);
        chk("dis_word",  32'(word), 32'h033);
        chk("dis_nbits", 32'(nbits), 32'd8);
        chk("dis_cs",    32'(cs_cycles), 32'd34);
        chk("dis_ready", 32'(ready_c), 32'hFFFFFFFF);
        s_if.wfg_drive_spi_tvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dis_no_start_cs", 32'(cs), 32'd1);
            chk("dis_tready",      32'(s_if.wfg_drive_spi_tready_o), 32'd0);
        end
        s_if.wfg_drive_spi_tvalid_i = 1'b0;

        // Re-enable, start a word, reset at SCLK edge 5 (cycle 10)
        en = 1'b1;
        step();
        start_word(18'h3FFFF);
        for (int i = 0; i < 10; i++) step();
        chk("ab_pre_sclk", 32'(sclk), 32'd1);
        chk("ab_pre_cs",   32'(cs), 32'd0);
        chk("ab_pre_sdo",  32'(sdo), 32'd1);
        rst = 1'b1;
        step();
        chk("ab_sclk",   32'(sclk), 32'd0);
        chk("ab_cs",     32'(cs), 32'd1);
        chk("ab_sdo",    32'(sdo), 32'd0);
        chk("ab_tready", 32'(s_if.wfg_drive_spi_tready_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("ab_idle_tready", 32'(s_if.wfg_drive_spi_tready_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
